// File: rtl/cla_pipe_adder_pkg.sv
// Shared types and sizing constants for the pipelined lookahead adder.
// Purely declarative: no logic, no latency, no flow control.
package cla_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    ADC  = 2'd2,
    RSVD = 2'd3
  } op_e;

  localparam int GROUP_W = 4;
  localparam int BLOCK_W = 16;

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle; slave is the adder, master drives operands and out_ready.
// No logic: valid/ready on both sides, in_ready may depend combinationally on out_ready.
interface cla_pipe_adder_if import cla_pkg::*; #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_e              op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );

endinterface

// File: rtl/cla_pipe_adder_lookahead.sv
// 4-wide lookahead carry unit, used for bits within a group and for groups within a block.
// Combinational, zero latency, no flow control; c[0] is the carry-in passed through.
module lookahead_unit4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c,
  output logic       gp,
  output logic       gg
);

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign gp = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage lookahead add/sub/adc with flags; latency 2, one op per cycle when out_ready is held.
// Full pipe with out_ready low drops in_ready; both stages hold until the output drains.
module cla_pipe_adder import cla_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_pipe_adder_if.slave    bus
);

  localparam int NG = WIDTH / GROUP_W;
  localparam int NB = WIDTH / BLOCK_W;

  if (WIDTH < BLOCK_W || (WIDTH % BLOCK_W) != 0) begin : g_width_chk
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 16");
  end

  // ---------------- stage 1: operand conditioning and group P/G
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [WIDTH-1:0] p_in, g_in;
  logic [NG-1:0]    gp_in, gg_in;
  logic [WIDTH-1:0] s1_c_unused;

  always_comb begin
    b_eff = (bus.op == SUB) ? ~bus.b : bus.b;
    case (bus.op)
      SUB:     c0 = 1'b1;
      ADC:     c0 = bus.cin;
      default: c0 = 1'b0;
    endcase
  end

  assign p_in = bus.a ^ b_eff;
  assign g_in = bus.a & b_eff;

  for (genvar j = 0; j < NG; j++) begin : g_grp_s1
    lookahead_unit4 u_grp (
      .p   (p_in[GROUP_W*j +: GROUP_W]),
      .g   (g_in[GROUP_W*j +: GROUP_W]),
      .cin (1'b0),
      .c   (s1_c_unused[GROUP_W*j +: GROUP_W]),
      .gp  (gp_in[j]),
      .gg  (gg_in[j])
    );
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic [NG-1:0]    s1_gp, s1_gg;
  logic             s1_c0;
  // Only the operand sign bits are needed downstream (overflow); p/g carry the rest.
  logic             s1_a_msb, s1_b_msb;

  // ---------------- stage 2: block lookahead, block ripple, bit carries
  logic [NG-1:0]    gc;
  logic [NB-1:0]    bp, bg;
  logic [NB:0]      bc;
  logic [WIDTH-1:0] bit_c;
  logic [NG-1:0]    gp2_unused, gg2_unused;
  logic [WIDTH-1:0] res_sum;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    lookahead_unit4 u_blk (
      .p   (s1_gp[GROUP_W*k +: GROUP_W]),
      .g   (s1_gg[GROUP_W*k +: GROUP_W]),
      .cin (bc[k]),
      .c   (gc[GROUP_W*k +: GROUP_W]),
      .gp  (bp[k]),
      .gg  (bg[k])
    );
  end

  always_comb begin
    bc[0] = s1_c0;
    for (int k = 0; k < NB; k++) begin
      bc[k+1] = bg[k] | (bp[k] & bc[k]);
    end
  end

  for (genvar j = 0; j < NG; j++) begin : g_grp_s2
    lookahead_unit4 u_bit (
      .p   (s1_p[GROUP_W*j +: GROUP_W]),
      .g   (s1_g[GROUP_W*j +: GROUP_W]),
      .cin (gc[j]),
      .c   (bit_c[GROUP_W*j +: GROUP_W]),
      .gp  (gp2_unused[j]),
      .gg  (gg2_unused[j])
    );
  end

  assign res_sum = s1_p ^ bit_c;

  // ---------------- handshake and registers
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q, neg_q;
  logic             accept, s1_adv;

  assign bus.in_ready = !s1_valid || !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign s1_adv       = s1_valid && (!out_valid_q || bus.out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_p     <= p_in;
        s1_g     <= g_in;
        s1_gp    <= gp_in;
        s1_gg    <= gg_in;
        s1_c0    <= c0;
        s1_a_msb <= bus.a[WIDTH-1];
        s1_b_msb <= b_eff[WIDTH-1];
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_valid_q <= 1'b1;
        sum_q       <= res_sum;
        cout_q      <= bc[NB];
        ovf_q       <= (s1_a_msb == s1_b_msb) && (res_sum[WIDTH-1] != s1_a_msb);
        zero_q      <= ~|res_sum;
        neg_q       <= res_sum[WIDTH-1];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed corner vectors, back-pressure, mid-flight reset,
// and randomized traffic scored against an arithmetic reference model.
module tb_cla_pipe_adder;
  import cla_pkg::*;

  localparam int W = 32;

  typedef struct {
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } txn_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  logic clk;
  logic rst_n;

  cla_pipe_adder_if #(.WIDTH(W))  bus ();
  cla_pipe_adder_if #(.WIDTH(64)) bus64 ();

  cla_pipe_adder #(.WIDTH(W))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  cla_pipe_adder #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         n_out = 0;
  int         n_acc = 0;
  bit         prev_stall = 1'b0;
  logic [W-1:0] prev_sum;
  txn_t       send_q[$];
  res_t       exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input txn_t t);
    res_t   r;
    longint sa, sb, full, smax, smin;
    logic [W:0] wide;
    sa   = longint'($signed(t.a));
    sb   = longint'($signed(t.b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    case (t.op)
      SUB: begin
        wide   = {1'b0, t.a} - {1'b0, t.b};
        r.cout = (t.a >= t.b);
        full   = sa - sb;
      end
      ADC: begin
        wide   = {1'b0, t.a} + {1'b0, t.b} + {{W{1'b0}}, t.cin};
        r.cout = wide[W];
        full   = sa + sb + longint'(t.cin);
      end
      default: begin
        wide   = {1'b0, t.a} + {1'b0, t.b};
        r.cout = wide[W];
        full   = sa + sb;
      end
    endcase
    r.sum  = wide[W-1:0];
    r.ovf  = (full > smax) || (full < smin);
    r.zero = (r.sum == '0);
    r.neg  = r.sum[W-1];
    return r;
  endfunction

  task automatic compare_res(input string tag, input res_t e);
    check({tag, "_sum"},  bus.sum,  e.sum);
    check({tag, "_cout"}, bus.cout, e.cout);
    check({tag, "_ovf"},  bus.ovf,  e.ovf);
    check({tag, "_zero"}, bus.zero, e.zero);
    check({tag, "_neg"},  bus.neg,  e.neg);
  endtask

  // One cycle of queued traffic: drive at negedge, sample 1ns later, score transfers.
  task automatic step(input bit rdy, output bit ir, output bit ov);
    txn_t t;
    @(negedge clk);
    if (send_q.size() > 0) begin
      t = send_q[0];
      bus.in_valid = 1'b1;
      bus.a        = t.a;
      bus.b        = t.b;
      bus.op       = t.op;
      bus.cin      = t.cin;
    end else begin
      bus.in_valid = 1'b0;
    end
    bus.out_ready = rdy;
    #1;
    ir = bus.in_ready;
    ov = bus.out_valid;
    if (prev_stall) begin
      check("hold_valid", ov, 1);
      check("hold_sum", bus.sum, prev_sum);
    end
    if (ov && rdy) begin
      if (exp_q.size() == 0) check("extra_result", bus.out_valid, 0);
      else begin
        compare_res("res", exp_q.pop_front());
        n_out++;
      end
    end
    prev_stall = ov && !rdy;
    prev_sum   = bus.sum;
    if (bus.in_valid && ir) begin
      exp_q.push_back(model(send_q.pop_front()));
      n_acc++;
    end
  endtask

  task automatic run_one(input string tag, input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] es, input logic ec, input logic eo,
                         input logic ez, input logic en);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.cin       = cin;
    bus.out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check({tag, "_lat1"}, bus.out_valid, 0);
    @(negedge clk);
    #1;
    check({tag, "_lat2"}, bus.out_valid, 1);
    check({tag, "_sum"},  bus.sum,  es);
    check({tag, "_cout"}, bus.cout, ec);
    check({tag, "_ovf"},  bus.ovf,  eo);
    check({tag, "_zero"}, bus.zero, ez);
    check({tag, "_neg"},  bus.neg,  en);
  endtask

  function automatic txn_t mk(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    txn_t t;
    t.op = op; t.a = a; t.b = b; t.cin = cin;
    return t;
  endfunction

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    bit ir, ov;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.op          = ADD;
    bus.cin         = 1'b0;
    bus.out_ready   = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.a         = '0;
    bus64.b         = '0;
    bus64.op        = ADD;
    bus64.cin       = 1'b0;
    bus64.out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum",  bus.sum,  0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf",  bus.ovf,  0);
    check("rst_zero", bus.zero, 0);
    check("rst_neg",  bus.neg,  0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    // directed corner vectors
    run_one("add_wrap", ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("sub_neg",  SUB, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("add_ovf",  ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_one("adc_blk",  ADC, 32'h0000_FFFF, 32'h0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("add_nocin", ADD, 32'd10, 32'd20, 1'b1, 32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("rsvd_add", RSVD, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("sub_pos",  SUB, 32'd7, 32'd5, 1'b0, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    run_one("sub_ovf",  SUB, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_one("sub_zero", SUB, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    // 64-bit ADC across a 48-bit carry chain
    @(negedge clk);
    bus64.in_valid = 1'b1;
    bus64.a        = 64'h0000_FFFF_FFFF_FFFF;
    bus64.b        = 64'h0;
    bus64.op       = ADC;
    bus64.cin      = 1'b1;
    @(negedge clk);
    bus64.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("adc64_valid", bus64.out_valid, 1);
    check("adc64_sum",   bus64.sum, 64'h0001_0000_0000_0000);
    check("adc64_cout",  bus64.cout, 0);
    check("adc64_zero",  bus64.zero, 0);

    // back-pressure: 1+1..4+4, out_ready low for 3 cycles after first out_valid
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_out = 0;
    for (int i = 1; i <= 4; i++) send_q.push_back(mk(ADD, W'(i), W'(i), 1'($urandom_range(0, 1))));
    step(1'b1, ir, ov);
    check("bp_c0_in_ready", ir, 1);
    check("bp_c0_out_valid", ov, 0);
    step(1'b1, ir, ov);
    check("bp_c1_in_ready", ir, 1);
    check("bp_c1_out_valid", ov, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, ir, ov);
      check("bp_stall_out_valid", ov, 1);
      check("bp_stall_in_ready", ir, 0);
    end
    for (int i = 0; i < 20 && (send_q.size() > 0 || exp_q.size() > 0); i++) step(1'b1, ir, ov);
    check("bp_count", n_out, 4);
    check("bp_pending", send_q.size() + exp_q.size(), 0);
    step(1'b1, ir, ov);
    check("bp_bubble", ov, 0);

    // randomized traffic with random bubbles and back-pressure
    n_out = 0;
    n_acc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (send_q.size() == 0 && $urandom_range(0, 3) != 0) begin
        txn_t t;
        t.op  = op_e'($urandom_range(0, 3));
        t.a   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom());
        t.b   = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : W'($urandom());
        t.cin = 1'($urandom_range(0, 1));
        send_q.push_back(t);
      end
      step($urandom_range(0, 3) != 0, ir, ov);
    end
    for (int i = 0; i < 50 && (send_q.size() > 0 || exp_q.size() > 0); i++) step(1'b1, ir, ov);
    check("rand_drain", send_q.size() + exp_q.size(), 0);
    check("rand_count", n_out, n_acc);

    // reset with both stages full and a handshake in the same cycle
    send_q.push_back(mk(ADD, 32'd100, 32'd1, 1'b0));
    send_q.push_back(mk(ADD, 32'd200, 32'd2, 1'b0));
    step(1'b1, ir, ov);
    step(1'b0, ir, ov);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 32'd300;
    bus.b         = 32'd3;
    bus.op        = ADD;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_sum",  bus.sum,  0);
    check("mrst_flags", {bus.cout, bus.ovf, bus.zero, bus.neg}, 0);
    check("mrst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    send_q.delete();
    exp_q.delete();
    prev_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ir, ov);
      check("mrst_no_stale", ov, 0);
    end
    n_out = 0;
    send_q.push_back(mk(SUB, 32'd9, 32'd4, 1'b0));
    for (int i = 0; i < 10 && (send_q.size() > 0 || exp_q.size() > 0); i++) step(1'b1, ir, ov);
    check("post_rst_count", n_out, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
